// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-addressed data-memory interface.
// Handles byte/halfword/word loads and stores from the datapath. Sub-word
// stores are done as read-modify-write because the memory writes whole words.
// Misaligned, reserved-size and out-of-range requests complete with resp_err
// after one cycle and never strobe the memory.
// Optional feature macro: LSU_PERF_CNT_EN (adds load/store/error counters).
module load_store_unit #(
  parameter int MEM_ADDR_BITS = 10,
  parameter bit CHECK_RANGE   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RMW_WR = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t      state_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] addr_q;
  logic [31:0] mem_wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;

  logic        accept_s;
  logic        out_of_range_s;
  logic        req_err_s;

  // Select the addressed lane of a memory word and sign/zero-extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the low bits of the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] new_d,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = old_w;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'b00:   m[7:0]   = new_d[7:0];
          2'b01:   m[15:8]  = new_d[7:0];
          2'b10:   m[23:16] = new_d[7:0];
          2'b11:   m[31:24] = new_d[7:0];
          default: m = old_w;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) m[31:16] = new_d[15:0];
        else         m[15:0]  = new_d[15:0];
      end
      default: m = new_d;
    endcase
    return m;
  endfunction

  assign accept_s       = req_valid & req_ready_q;
  assign out_of_range_s = ((req_addr >> MEM_ADDR_BITS) != 32'd0);

  // Classify an incoming request as erroneous (alignment, reserved size, range).
  always_comb begin
    req_err_s = 1'b0;
    case (req_size)
      SZ_BYTE: req_err_s = 1'b0;
      SZ_HALF: req_err_s = req_addr[0];
      SZ_WORD: req_err_s = (req_addr[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
    if (CHECK_RANGE && out_of_range_s) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
  end

  // Main FSM: sequences accept, memory access, optional write-back and response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      // strobes and the response are single-cycle pulses by default
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            addr_q       <= req_addr;
            size_q       <= req_size;
            signed_q     <= req_signed;
            write_q      <= req_write;
            mem_wdata_q  <= req_wdata;
            resp_rdata_q <= 32'h0000_0000;
            if (req_err_s) begin
              state_q      <= ST_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              req_ready_q  <= 1'b1;
            end else begin
              state_q     <= ST_ACCESS;
              resp_err_q  <= 1'b0;
              req_ready_q <= 1'b0;
              // only a full-word store can write without reading first
              if (req_write && (req_size == SZ_WORD)) mem_write_q <= 1'b1;
              else                                    mem_read_q  <= 1'b1;
            end
          end else begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            resp_err_q  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (write_q && (size_q == SZ_WORD)) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
          end else if (write_q) begin
            mem_wdata_q <= merge_lane(mem_rdata, mem_wdata_q, size_q, addr_q[1:0]);
            mem_write_q <= 1'b1;
            state_q     <= ST_RMW_WR;
          end else begin
            resp_rdata_q <= extend_load(mem_rdata, size_q, addr_q[1:0], signed_q);
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
          end
        end
        ST_RMW_WR: begin
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = mem_wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_cnt_q;
  logic [15:0] store_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Count completed accesses by type; errored accesses go to err_cnt only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q  <= 16'h0000;
      store_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else if (resp_valid_q) begin
      if (resp_err_q)   err_cnt_q   <= sat_inc(err_cnt_q);
      else if (write_q) store_cnt_q <= sat_inc(store_cnt_q);
      else              load_cnt_q  <= sat_inc(load_cnt_q);
    end else begin
      load_cnt_q <= load_cnt_q;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small 256x32 memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;
  logic [15:0] err_cnt;
`endif

  load_store_unit #(.MEM_ADDR_BITS(10), .CHECK_RANGE(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef LSU_PERF_CNT_EN
    ,
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // memory model: combinational read, synchronous write, preload port for setup
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic both_seen = 1'b0;

  // per-request observations
  int          r_lat;
  int          r_nrd;
  int          r_nwr;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_wdata;
  logic [31:0] r_waddr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  // Issue one request; call at a negedge. Returns at the negedge where resp_valid is seen.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    r_lat = 0; r_nrd = 0; r_nwr = 0;
    r_rdata = 32'h0; r_err = 1'b0; r_wdata = 32'h0; r_waddr = 32'h0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_read) r_nrd++;
      if (mem_write) begin
        r_nwr++;
        r_wdata = mem_wdata;
        r_waddr = mem_addr;
      end
      if (mem_read && mem_write) both_seen = 1'b1;
      if (resp_valid) begin
        r_lat   = c;
        r_rdata = resp_rdata;
        r_err   = resp_err;
        break;
      end
    end
    if (r_lat == 0) check_eq("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int any_resp;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 8'h00; pl_data = 32'h0;

    preload(8'd0,   32'h0000_0000);
    preload(8'd25,  32'h1122_3344);
    preload(8'd26,  32'h0000_0085);
    preload(8'd27,  32'h8001_7FFE);
    preload(8'd100, 32'h0000_0000);

    // reset state
    check_eq("rst_ready",  {31'd0, req_ready},  32'd1);
    check_eq("rst_resp",   {31'd0, resp_valid}, 32'd0);
    check_eq("rst_mrd",    {31'd0, mem_read},   32'd0);
    check_eq("rst_mwr",    {31'd0, mem_write},  32'd0);
    check_eq("rst_maddr",  mem_addr,            32'h0);
    check_eq("rst_rdata",  resp_rdata,          32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // lb signed
    do_req(1'b0, 2'b00, 1'b1, 32'd104, 32'h0);
    check_eq("lb_data", r_rdata, 32'hFFFF_FF85);
    check_eq("lb_err",  {31'd0, r_err}, 32'd0);
    check_eq("lb_lat",  r_lat, 32'd2);
    check_eq("lb_nrd",  r_nrd, 32'd1);
    check_eq("lb_nwr",  r_nwr, 32'd0);
    @(negedge clk);

    // lbu
    do_req(1'b0, 2'b00, 1'b0, 32'd104, 32'h0);
    check_eq("lbu_data", r_rdata, 32'h0000_0085);
    @(negedge clk);

    // lb of upper byte (zero) of the same word
    do_req(1'b0, 2'b00, 1'b1, 32'd107, 32'h0);
    check_eq("lb3_data", r_rdata, 32'h0000_0000);
    @(negedge clk);

    // sb read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 32'd101, 32'h0000_00AA);
    check_eq("sb_nrd",   r_nrd, 32'd1);
    check_eq("sb_nwr",   r_nwr, 32'd1);
    check_eq("sb_wdata", r_wdata, 32'h1122_AA44);
    check_eq("sb_waddr", r_waddr, 32'd100);
    check_eq("sb_lat",   r_lat, 32'd3);
    check_eq("sb_rdata", r_rdata, 32'h0);
    check_eq("sb_mem",   mem[25], 32'h1122_AA44);
    @(negedge clk);

    // halfword loads, both lanes
    do_req(1'b0, 2'b01, 1'b1, 32'd110, 32'h0);
    check_eq("lh_hi", r_rdata, 32'hFFFF_8001);
    @(negedge clk);
    do_req(1'b0, 2'b01, 1'b0, 32'd108, 32'h0);
    check_eq("lhu_lo", r_rdata, 32'h0000_7FFE);
    @(negedge clk);

    // sh read-modify-write into lane 0
    do_req(1'b1, 2'b01, 1'b0, 32'd108, 32'hFFFF_1234);
    check_eq("sh_wdata", r_wdata, 32'h8001_1234);
    check_eq("sh_lat",   r_lat, 32'd3);
    @(negedge clk);

    // sw then back-to-back lw accepted in DONE
    do_req(1'b1, 2'b10, 1'b0, 32'd400, 32'hDEAD_BEEF);
    check_eq("sw_nrd",   r_nrd, 32'd0);
    check_eq("sw_nwr",   r_nwr, 32'd1);
    check_eq("sw_waddr", r_waddr, 32'd400);
    check_eq("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check_eq("sw_lat",   r_lat, 32'd2);
    check_eq("b2b_ready", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'd400, 32'h0);
    check_eq("lw_data", r_rdata, 32'hDEAD_BEEF);
    check_eq("lw_lat",  r_lat, 32'd2);
    @(negedge clk);

    // error cases
    do_req(1'b0, 2'b01, 1'b1, 32'd103, 32'h0);
    check_eq("lh103_err", {31'd0, r_err}, 32'd1);
    check_eq("lh103_lat", r_lat, 32'd1);
    check_eq("lh103_strb", r_nrd + r_nwr, 32'd0);
    check_eq("lh103_data", r_rdata, 32'h0);
    @(negedge clk);
    do_req(1'b1, 2'b10, 1'b0, 32'd2, 32'h1234_5678);
    check_eq("sw2_err",  {31'd0, r_err}, 32'd1);
    check_eq("sw2_lat",  r_lat, 32'd1);
    check_eq("sw2_strb", r_nrd + r_nwr, 32'd0);
    check_eq("sw2_mem",  mem[0], 32'h0);
    @(negedge clk);
    do_req(1'b0, 2'b10, 1'b0, 32'd1024, 32'h0);
    check_eq("lw1024_err",  {31'd0, r_err}, 32'd1);
    check_eq("lw1024_lat",  r_lat, 32'd1);
    check_eq("lw1024_strb", r_nrd + r_nwr, 32'd0);
    check_eq("lw1024_data", r_rdata, 32'h0);
    @(negedge clk);
    do_req(1'b0, 2'b11, 1'b0, 32'd104, 32'h0);
    check_eq("rsv_err", {31'd0, r_err}, 32'd1);
    @(negedge clk);
    // a good load right after an error must report no error
    do_req(1'b0, 2'b10, 1'b0, 32'd104, 32'h0);
    check_eq("ok_err",  {31'd0, r_err}, 32'd0);
    check_eq("ok_data", r_rdata, 32'h0000_0085);
    @(negedge clk);

    // reset during RMW_WR
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd100; req_wdata = 32'h0000_0055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("rr_access_rd", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check_eq("rr_rmw_wr", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rr_mwr_drop", {31'd0, mem_write},  32'd0);
    check_eq("rr_ready",    {31'd0, req_ready},  32'd1);
    check_eq("rr_resp",     {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    any_resp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) any_resp++;
    end
    check_eq("rr_no_resp", any_resp, 32'd0);
    check_eq("rr_mem",     mem[25], 32'h1122_AA44);

    check_eq("strobe_overlap", {31'd0, both_seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
